// File: rtl/pwmdac_pkg.sv
// Shared defaults and constant helpers for the PWM DAC family.
// Midscale and saturation limits are expressed in signed quantiser units.
package pwmdac_pkg;

   localparam int DEF_DIN_W    = 16;
   localparam int DEF_PWM_BITS = 7;
   localparam int DEF_OS_LOG2  = 1;

   function automatic int midscale(input int pwm_bits);
      return 32'sd1 <<< (pwm_bits - 32'sd1);
   endfunction

   function automatic int sat_hi(input int pwm_bits);
      return (32'sd1 <<< (pwm_bits - 32'sd1)) - 32'sd1;
   endfunction

   function automatic int sat_lo(input int pwm_bits);
      return -(32'sd1 <<< (pwm_bits - 32'sd1));
   endfunction

endpackage

// File: rtl/pwmdac_ns_quant.sv
// Combinational quantiser: adds the error residual, floors to PWM resolution,
// saturates to the signed code range and emits the offset-binary duty.
module pwmdac_ns_quant
   import pwmdac_pkg::*;
#(
   parameter int DIN_W    = DEF_DIN_W,
   parameter int PWM_BITS = DEF_PWM_BITS,
   parameter int FRAC_W   = DIN_W - PWM_BITS
) (
   input  logic [DIN_W-1:0]    i_x,
   input  logic [FRAC_W-1:0]   i_e,
   output logic [PWM_BITS-1:0] o_duty,
   output logic [FRAC_W-1:0]   o_resid,
   output logic                o_sat
);

   localparam logic signed [PWM_BITS:0] Q_HI  = (PWM_BITS + 1)'(sat_hi(PWM_BITS));
   localparam logic signed [PWM_BITS:0] Q_LO  = (PWM_BITS + 1)'(sat_lo(PWM_BITS));
   localparam logic signed [PWM_BITS:0] Q_MID = (PWM_BITS + 1)'(midscale(PWM_BITS));

   logic signed [DIN_W:0]    w_v;
   logic signed [PWM_BITS:0] w_q;
   logic signed [PWM_BITS:0] w_q_sat;

   // The sum cannot overflow DIN_W+1 bits since the residual is below 2^FRAC_W.
   assign w_v     = $signed({i_x[DIN_W-1], i_x}) + $signed({{(DIN_W + 1 - FRAC_W){1'b0}}, i_e});
   assign w_q     = w_v[DIN_W:FRAC_W];
   assign o_resid = w_v[FRAC_W-1:0];

   // Clamp the floored code to the representable duty range.
   always_comb begin
      w_q_sat = w_q;
      o_sat   = 1'b0;
      if (w_q > Q_HI) begin
         w_q_sat = Q_HI;
         o_sat   = 1'b1;
      end else if (w_q < Q_LO) begin
         w_q_sat = Q_LO;
         o_sat   = 1'b1;
      end else begin
         w_q_sat = w_q;
         o_sat   = 1'b0;
      end
   end

   assign o_duty = PWM_BITS'(w_q_sat + Q_MID);

endmodule

// File: rtl/pwmdac_ns.sv
// Pull-interface PWM DAC with optional first-order error-feedback noise shaping.
// One sample is pulled every 2^(PWM_BITS+OS_LOG2) enabled clocks.
module pwmdac_ns
   import pwmdac_pkg::*;
#(
   parameter int DIN_W    = DEF_DIN_W,
   parameter int PWM_BITS = DEF_PWM_BITS,
   parameter int OS_LOG2  = DEF_OS_LOG2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ns_en,
   input  logic [DIN_W-1:0] din,
   output logic             din_ack,
   output logic             dacout
);

   localparam int FRAC_W = DIN_W - PWM_BITS;
   localparam int FRM_W  = (OS_LOG2 > 0) ? OS_LOG2 : 1;
   localparam logic [FRM_W-1:0]    FRM_LAST  = FRM_W'((32'd1 << OS_LOG2) - 32'd1);
   localparam logic [PWM_BITS-1:0] PWM_LAST  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] DUTY_MID  = PWM_BITS'(midscale(PWM_BITS));

   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [FRM_W-1:0]    r_frame_cnt;
   logic [DIN_W-1:0]    r_sample;
   logic [FRAC_W-1:0]   r_err;
   logic [PWM_BITS-1:0] r_duty;
   logic                r_dacout;
   logic                r_din_ack;

   logic                w_frame_end;
   logic                w_sample_end;
   logic [DIN_W-1:0]    w_x;
   logic [FRAC_W-1:0]   w_e;
   logic [PWM_BITS-1:0] w_q_duty;
   logic [FRAC_W-1:0]   w_resid;
   logic                w_sat;

   assign w_frame_end  = (r_pwm_cnt == PWM_LAST);
   assign w_sample_end = w_frame_end && (r_frame_cnt == FRM_LAST);

   // Quantiser operands: the incoming sample bypasses the register on a sample end.
   always_comb begin
      w_x = r_sample;
      w_e = {FRAC_W{1'b0}};
      if (w_sample_end) begin
         w_x = din;
      end else begin
         w_x = r_sample;
      end
      if (ns_en) begin
         w_e = r_err;
      end else begin
         w_e = {FRAC_W{1'b0}};
      end
   end

   pwmdac_ns_quant #(
      .DIN_W    (DIN_W),
      .PWM_BITS (PWM_BITS),
      .FRAC_W   (FRAC_W)
   ) u_quant (
      .i_x     (w_x),
      .i_e     (w_e),
      .o_duty  (w_q_duty),
      .o_resid (w_resid),
      .o_sat   (w_sat)
   );

   // Counters, sample/error/duty state, PWM comparator and pull handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm_cnt   <= {PWM_BITS{1'b0}};
         r_frame_cnt <= {FRM_W{1'b0}};
         r_sample    <= {DIN_W{1'b0}};
         r_err       <= {FRAC_W{1'b0}};
         r_duty      <= DUTY_MID;
         r_dacout    <= 1'b0;
         r_din_ack   <= 1'b0;
      end else if (!en) begin
         r_dacout  <= 1'b0;
         r_din_ack <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
         r_dacout  <= (r_pwm_cnt < r_duty);
         r_din_ack <= w_sample_end;
         if (w_frame_end) begin
            r_duty <= w_q_duty;
            // Residual is only carried while shaping and after an unsaturated frame.
            if (ns_en && !w_sat) begin
               r_err <= w_resid;
            end else begin
               r_err <= {FRAC_W{1'b0}};
            end
            if (w_sample_end) begin
               r_frame_cnt <= {FRM_W{1'b0}};
               r_sample    <= din;
            end else begin
               r_frame_cnt <= r_frame_cnt + FRM_W'(1);
            end
         end
      end
   end

   assign dacout  = r_dacout;
   assign din_ack = r_din_ack;

endmodule

// File: tb/tb_pwmdac_ns.sv
// Scoreboard bench for pwmdac_ns at default parameters: the driver pushes
// expected per-frame high counts and ack cycles, the monitor pops and compares.
module tb_pwmdac_ns;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        en    = 1'b1;
   logic        ns_en = 1'b0;
   logic [15:0] din   = 16'h0000;
   logic        din_ack;
   logic        dacout;

   int cyc    = 0;
   int n_vec  = 0;
   int n_miss = 0;
   int ak     = 0;
   int ones   = 0;
   int q_frame[$];
   int q_ack[$];

   // Per-sample vectors: din, ns_en, expected high counts of its two frames.
   logic [15:0] t_din [1:11] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0100, 16'h0100, 16'h0100,
                                 16'h01FF, 16'h7FFF, 16'h0001, 16'h0000, 16'h01FF};
   logic        t_ns  [1:11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   int          t_f0  [1:11] = '{64, 127, 0, 64, 64, 64, 64, 127, 65, 64, 64};
   int          t_f1  [1:11] = '{64, 127, 0, 64, 65, 65, 65, 127, 64, 64, 65};

   pwmdac_ns dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .ns_en   (ns_en),
      .din     (din),
      .din_ack (din_ack),
      .dacout  (dacout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         check("rst_dacout", int'(dacout), 0);
         check("rst_ack", int'(din_ack), 0);
         ak   = 0;
         ones = 0;
      end else if (!en) begin
         check("idle_dacout", int'(dacout), 0);
         check("idle_ack", int'(din_ack), 0);
      end else begin
         ones += int'(dacout);
         if (din_ack) begin
            if (q_ack.size() == 0) check("ack_spurious", cyc, -1);
            else check("ack_cycle", cyc, q_ack.pop_front());
         end
         if (ak % 128 == 127) begin
            if (q_frame.size() == 0) check("frame_extra", ones, -1);
            else check("frame_high", ones, q_frame.pop_front());
            ones = 0;
         end
         ak++;
      end
   end

   initial begin
      q_frame.push_back(64);
      q_frame.push_back(64);
      q_ack.push_back(260);
      wait_cyc(4);
      rst = 1'b0;
      for (int s = 1; s <= 11; s++) begin
         wait_cyc(5 + 256 * s - 100);
         din   = t_din[s];
         ns_en = t_ns[s];
         q_frame.push_back(t_f0[s]);
         q_frame.push_back(t_f1[s]);
         q_ack.push_back(260 + 256 * s);
      end
      wait_cyc(2977);
      din   = 16'h0000;
      ns_en = 1'b0;
      // Reset pulse lands on pwm_cnt 50 of the interrupted frame.
      wait_cyc(3126);
      rst = 1'b1;
      q_frame.push_back(64);
      q_frame.push_back(64);
      q_ack.push_back(3383);
      wait_cyc(3127);
      rst = 1'b0;
      wait_cyc(3283);
      din = 16'h4000;
      q_frame.push_back(96);
      q_frame.push_back(96);
      q_ack.push_back(3739);
      wait_cyc(3413);
      en = 1'b0;
      wait_cyc(3513);
      en = 1'b1;
      wait_cyc(3650);
      din = 16'hC000;
      q_frame.push_back(32);
      q_frame.push_back(32);
      q_ack.push_back(3995);
      wait_cyc(4010);
      check("frames_left", q_frame.size(), 0);
      check("acks_left", q_ack.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pwmdac_ns.md
Name: pwmdac_ns

Overview:
Parametrised successor to the 8-bit PWM DAC: a pull-interface PWM DAC with configurable input width, PWM resolution and PWM frames per sample. Adds optional first-order error-feedback noise shaping with saturation, plus a run enable. Sits between the speech synthesiser's sample output and the 1-bit output pin/RC filter. Defaults give a 10 ksps rate with a 20 kHz carrier at 2.56 MHz.

Parameters:
DIN_W, 16, signed input sample width; must be > PWM_BITS
PWM_BITS, 7, PWM resolution; frame length 2^PWM_BITS clocks; >= 2
OS_LOG2, 1, log2 of PWM frames per sample; sample period 2^(PWM_BITS+OS_LOG2) clocks; 0 allowed

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  run enable
ns_en  in  1  noise-shaping enable; sampled at frame boundaries only
din  in  DIN_W  signed sample, pulled at end of each sample period
din_ack  out  1  one-cycle pulse in the cycle after din is latched
dacout  out  1  registered PWM output

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- Reset values: pwm_cnt=0, frame_cnt=0, sample=0, err=0, duty=2^(PWM_BITS-1) (midscale), dacout=0, din_ack=0. rst overrides en.
- en=0: all state held; dacout<=0; din_ack<=0. When en returns to 1, counting resumes from the held values.
- en=1, every clock: pwm_cnt<=pwm_cnt+1, wrapping at 2^PWM_BITS-1. dacout<=(pwm_cnt<duty), unsigned compare on pre-edge values, so dacout lags the counter by 1 clock.
- Frame end (pwm_cnt all ones): frame_cnt increments and wraps. Sample end is frame end with frame_cnt all ones; with OS_LOG2=0 every frame end is a sample end.
- At sample end: sample<=din; din_ack<=1 on the next cycle, otherwise din_ack=0.
- At every frame end the quantiser computes the next frame's duty from x:
  - x = din if this is a sample end, else the sample register.
  - F = DIN_W-PWM_BITS; e = err if ns_en else 0.
  - v = x + e, width DIN_W+1 signed; q = v >>> F (floor).
  - q saturates to [-2^(PWM_BITS-1), 2^(PWM_BITS-1)-1].
  - duty <= q + 2^(PWM_BITS-1), offset binary.
  - err <= v[F-1:0] (unsigned residual, 0..2^F-1).
  - err <= 0 if q saturated or ns_en=0.
- Full scale: duty max is 2^PWM_BITS-1, so dacout is never high for an entire frame. duty 0 gives constant low.
- Latency: din latched at sample-end edge T. The frame using it starts at T+1; its first dacout bit appears at T+2.
- Simultaneous rst and sample end: reset wins; no ack is issued.

Decomposition:
- Shared include/package pwmdac_pkg holds the default DIN_W/PWM_BITS/OS_LOG2 and the midscale/saturation-limit constant functions, shared with the legacy DAC bench.
- One natural sub-module, pwmdac_ns_quant: combinational add, floor shift, saturate and residual, with a saturation flag out.
- Counters, sample/err/duty registers and handshake stay in the top level.

Test Plan:
Defaults throughout (frame 128 clk, sample 256 clk).
1. Release rst, en=1, din=0, ns_en=0 -> dacout high 64 of every 128 clocks. First din_ack 256 clocks after rst release, then every 256.
2. din=16'h7FFF -> high 127/128 per frame. din=16'h8000 -> dacout constantly 0 once the new frame starts.
3. din=16'h0100, ns_en=0 -> 64 high every frame. ns_en=1 -> frames alternate 64/65 high (err 256 then 0).
4. din=16'h01FF with ns_en=1 (err=511), then din=16'h7FFF -> q saturates at 63, duty=127, err register reads 0.
5. rst pulsed 1 clock at pwm_cnt=50 -> next cycle dacout=0, din_ack=0, counters=0, duty=64. Next din_ack 256 clocks after rst drops.
6. en low 100 clocks mid-frame -> dacout 0 and no ack during the gap. Subsequent din_ack arrives exactly 100 clocks later than without the gap, and the PWM pattern resumes unchanged.
